// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Increment an index modulo n (n-1 wraps to 0).
    function automatic int unsigned mod_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32
);
    localparam int IdxW = $clog2(NumReq);

    logic [NumReq-1:0]           req_valid;
    logic [NumReq*DataWidth-1:0] req_data;
    logic [NumReq-1:0]           req_ready;
    logic                        fifo_wr_en;
    logic [DataWidth-1:0]        fifo_wr_data;
    logic                        fifo_full;
    logic [IdxW-1:0]             grant_id;
    logic                        burst_active;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, burst_active
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, burst_active
    );
endinterface

// File: rtl/rr_pick.sv
// Cyclic priority search: first set bit of req at or after start, wrapping.
module rr_pick #(
    parameter int NumReq = 4
) (
    input  logic [NumReq-1:0]         req,
    input  logic [$clog2(NumReq)-1:0] start,
    output logic                      found,
    output logic [$clog2(NumReq)-1:0] idx
);
    localparam int IdxW = $clog2(NumReq);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = start;
        j     = 0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= NumReq) j = j - NumReq;
            if (req[j]) begin
                found = 1'b1;
                idx   = IdxW'(j);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin FIFO write arbiter with bounded bursts; data path is a
// zero-latency mux from the grantee onto the FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int MaxBurst  = 4
) (
    input logic          clk,
    input logic          rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IdxW = $clog2(NumReq);
    localparam int BW   = $clog2(MaxBurst) + 1;

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic                 pick_found;
    logic [IdxW-1:0]      pick_idx;
    logic [IdxW-1:0]      grantee;
    logic                 xfer;
    logic [NumReq-1:0]    ready_c;
    logic [DataWidth-1:0] data_c;

    rr_pick #(.NumReq(NumReq)) u_pick (
        .req   (bus.req_valid),
        .start (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant selection, handshake and write-port mux.
    always_comb begin
        if (state_q == BURST)  grantee = owner_q;
        else if (pick_found)   grantee = pick_idx;
        else                   grantee = rr_ptr_q;
        xfer    = bus.req_valid[grantee] && !bus.fifo_full;
        ready_c = '0;
        if (state_q == BURST || (|bus.req_valid)) ready_c[grantee] = !bus.fifo_full;
        data_c  = bus.req_data[int'(grantee)*DataWidth +: DataWidth];
    end

    // Outputs are forced to zero for as long as reset is held.
    assign bus.req_ready    = rst ? '0 : ready_c;
    assign bus.fifo_wr_en   = rst ? 1'b0 : xfer;
    assign bus.fifo_wr_data = rst ? '0 : data_c;
    assign bus.grant_id     = rst ? '0 : grantee;
    assign bus.burst_active = rst ? 1'b0 : (state_q == BURST);

    // Next-state: arbitration, burst counting and pointer advance.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB: begin
                if (xfer) begin
                    if (MaxBurst == 1) begin
                        rr_ptr_d = IdxW'(mod_inc(32'(grantee), NumReq));
                    end else begin
                        owner_d    = grantee;
                        beat_cnt_d = BW'(1);
                        state_d    = BURST;
                    end
                end
            end
            BURST: begin
                // A dropped request ends the burst; a full FIFO only stalls it.
                if (!bus.req_valid[owner_q]) begin
                    rr_ptr_d   = IdxW'(mod_inc(32'(owner_q), NumReq));
                    beat_cnt_d = '0;
                    state_d    = ARB;
                end else if (xfer) begin
                    if ((32'(beat_cnt_q) + 32'd1) == 32'(MaxBurst)) begin
                        rr_ptr_d   = IdxW'(mod_inc(32'(owner_q), NumReq));
                        beat_cnt_d = '0;
                        state_d    = ARB;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a MaxBurst=4 instance and a
// MaxBurst=1 instance, directed stimulus, negedge monitors.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NumReq(NR), .DataWidth(DW)) bus  ();
    fifo_wr_arbiter_if #(.NumReq(NR), .DataWidth(DW)) bus2 ();

    fifo_wr_arbiter #(.NumReq(NR), .DataWidth(DW), .MaxBurst(4)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    fifo_wr_arbiter #(.NumReq(NR), .DataWidth(DW), .MaxBurst(1)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   total = 0;
    int   bad   = 0;

    int            seq [NR];
    logic          seq_clr;
    logic [NR-1:0] acc;

    function automatic logic [DW-1:0] mk(input int i, input int s);
        return 32'hA000_0000 | (32'(i) << 16) | (32'(s) & 32'h0000_FFFF);
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Requester model: each requester presents its next beat once the previous one is accepted.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            bus.req_data[i*DW +: DW]  = mk(i, seq[i]);
            bus2.req_data[i*DW +: DW] = mk(i, 0);
        end
    end

    always @(negedge clk) acc <= bus.req_valid & bus.req_ready;

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (seq_clr)     seq[i] <= 0;
            else if (acc[i]) seq[i] <= seq[i] + 1;
        end
    end

    // Monitor for the MaxBurst=4 instance.
    always @(negedge clk) begin
        exp_t e;
        chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'(1));
        chk("write_while_full", 64'(bus.fifo_wr_en & bus.fifo_full), 64'(0));
        if (bus.fifo_wr_en === 1'b1) begin
            if (q1.size() == 0) begin
                chk("write_expected", 64'(q1.size()), 64'(1));
            end else begin
                e = q1.pop_front();
                chk("grant_id", 64'(bus.grant_id), 64'(e.id));
                chk("wr_data", 64'(bus.fifo_wr_data), 64'(e.data));
            end
        end
    end

    // Monitor for the MaxBurst=1 instance.
    always @(negedge clk) begin
        exp_t e;
        chk("mb1_burst_active", 64'(bus2.burst_active), 64'(0));
        if (bus2.fifo_wr_en === 1'b1) begin
            if (q2.size() == 0) begin
                chk("mb1_write_expected", 64'(q2.size()), 64'(1));
            end else begin
                e = q2.pop_front();
                chk("mb1_grant_id", 64'(bus2.grant_id), 64'(e.id));
                chk("mb1_wr_data", 64'(bus2.fifo_wr_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input int id, input int s);
        exp_t e;
        e.id   = id;
        e.data = mk(id, s);
        q1.push_back(e);
    endtask

    task automatic push2(input int id);
        exp_t e;
        e.id   = id;
        e.data = mk(id, 0);
        q2.push_back(e);
    endtask

    task automatic start_reset();
        rst            = 1'b1;
        seq_clr        = 1'b1;
        bus.req_valid  = '0;
        bus.fifo_full  = 1'b0;
        bus2.req_valid = '0;
        tick();
        tick();
    endtask

    task automatic release_with(input logic [NR-1:0] v);
        bus.req_valid = v;
        seq_clr       = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(bus.req_ready), 64'(0));
        chk({tag, "_wr_en"}, 64'(bus.fifo_wr_en), 64'(0));
        chk({tag, "_grant"}, 64'(bus.grant_id), 64'(0));
        chk({tag, "_data"},  64'(bus.fifo_wr_data), 64'(0));
        chk({tag, "_burst"}, 64'(bus.burst_active), 64'(0));
    endtask

    initial begin
        rst            = 1'b1;
        seq_clr        = 1'b1;
        bus.req_valid  = '0;
        bus.fifo_full  = 1'b0;
        bus2.req_valid = '0;
        bus2.fifo_full = 1'b0;

        // Reset state with requests pending.
        tick();
        bus.req_valid = 4'b0110;
        tick();
        @(negedge clk);
        check_reset_outputs("rst");

        // All four requesting: 4-beat bursts in order 0,1,2,3.
        tick();
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < 4; b++) push1(r, b);
        release_with(4'b1111);
        repeat (16) tick();
        bus.req_valid = '0;
        chk("all16_written", 64'(q1.size()), 64'(0));
        tick();

        // Req 2 alone for two beats, then drops.
        start_reset();
        push1(2, 0);
        push1(2, 1);
        release_with(4'b0100);
        tick();
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("drop_burst_still_active", 64'(bus.burst_active), 64'(1));
        chk("drop_no_write", 64'(bus.fifo_wr_en), 64'(0));
        tick();
        @(negedge clk);
        chk("drop_grant_rrptr", 64'(bus.grant_id), 64'(3));
        chk("drop_burst_ended", 64'(bus.burst_active), 64'(0));
        chk("drop_ready_idle", 64'(bus.req_ready), 64'(0));

        // Req 1 stalled by full FIFO at beat_cnt 2, then finishes.
        start_reset();
        for (int b = 0; b < 4; b++) push1(1, b);
        release_with(4'b0010);
        tick();
        tick();
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("full_wr_en", 64'(bus.fifo_wr_en), 64'(0));
            chk("full_ready", 64'(bus.req_ready), 64'(0));
            chk("full_burst_held", 64'(bus.burst_active), 64'(1));
            chk("full_beat_cnt", 64'(dut.beat_cnt_q), 64'(2));
            tick();
        end
        bus.fifo_full = 1'b0;
        tick();
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("full_burst_done", 64'(bus.burst_active), 64'(0));
        chk("full_two_more_beats", 64'(q1.size()), 64'(0));

        // Req 3 burst completes; pointer wraps to 0.
        start_reset();
        for (int b = 0; b < 4; b++) push1(3, b);
        push1(0, 0);
        release_with(4'b1000);
        tick();
        bus.req_valid = 4'b1001;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("wrap_grant0", 64'(bus.grant_id), 64'(0));
        chk("wrap_burst_idle", 64'(bus.burst_active), 64'(0));
        tick();
        bus.req_valid = '0;
        tick();

        // Reset mid-burst of req 1; restart arbitrates from 0.
        start_reset();
        push1(1, 0);
        release_with(4'b0010);
        tick();
        rst           = 1'b1;
        bus.req_valid = 4'b0011;
        @(negedge clk);
        check_reset_outputs("midrst1");
        tick();
        @(negedge clk);
        check_reset_outputs("midrst2");
        tick();
        push1(0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant0", 64'(bus.grant_id), 64'(0));
        chk("post_rst_wr", 64'(bus.fifo_wr_en), 64'(1));
        tick();
        bus.req_valid = '0;
        tick();
        chk("midrst_queue", 64'(q1.size()), 64'(0));

        // MaxBurst=1: strict rotation.
        start_reset();
        push2(0); push2(1); push2(2); push2(3); push2(0);
        bus2.req_valid = 4'b1111;
        release_with(4'b0000);
        repeat (5) tick();
        bus2.req_valid = '0;
        tick();
        chk("mb1_queue", 64'(q2.size()), 64'(0));

        chk("final_queue", 64'(q1.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
